// File: rtl/bit_stuff_pkg.sv
// Shared types and helpers for the bit stuffer/unstuffer engine.
package bit_stuff_pkg;

  typedef enum logic [1:0] {
    PASS = 2'd0,
    INS  = 2'd1,
    ERR  = 2'd2
  } bs_state_t;

  typedef enum logic {
    STUFF   = 1'b0,
    UNSTUFF = 1'b1
  } bs_mode_t;

  // Saturating increment for the 16-bit stuff statistics counter
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) r = v;
    else               r = v + 16'd1;
    return r;
  endfunction

  // Saturating increment for the 8-bit error statistics counter
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) r = v;
    else            r = v + 8'd1;
    return r;
  endfunction

endpackage

// File: rtl/counter.sv
// Generic up/down counter with synchronous clear.
// A clear and a count step in the same cycle yield the first step from zero.
module counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_L,
  input  logic         inc_cnt,
  input  logic         clr_cnt,
  input  logic         up,
  output logic [W-1:0] count
);

  logic [W-1:0] base_s;
  logic [W-1:0] count_nxt_s;

  assign base_s = clr_cnt ? {W{1'b0}} : count;

  // Next count: optional clear, then optional single step
  always_comb begin
    count_nxt_s = base_s;
    if (!inc_cnt) begin
      count_nxt_s = base_s;
    end else if (up) begin
      count_nxt_s = base_s + W'(1);
    end else begin
      count_nxt_s = base_s - W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) count <= {W{1'b0}};
    else        count <= count_nxt_s;
  end

endmodule

// File: rtl/bit_stuff_gen.sv
// Bit stuffer / unstuffer with valid/ready on both sides.
// STUFF mode inserts a 0 after MAX_RUN consecutive 1s; UNSTUFF mode removes
// that 0 and flags a 1 found in its place, then drains until the next start.
// Optional feature macro: BIT_STUFF_STATS_EN adds stuff_cnt / err_cnt outputs.
module bit_stuff_gen
  import bit_stuff_pkg::*;
#(
  parameter int MAX_RUN = 6,
  parameter int CNT_W   = $clog2(MAX_RUN + 1)
) (
  input  logic        clk,
  input  logic        rst_L,
  input  logic        start,
  input  logic        mode,
  input  logic        in_valid,
  input  logic        in_bit,
  output logic        in_ready,
  output logic        out_valid,
  output logic        out_bit,
  input  logic        out_ready,
  output logic        stuffed,
  output logic        stuff_err
`ifdef BIT_STUFF_STATS_EN
  ,
  output logic [15:0] stuff_cnt,
  output logic [7:0]  err_cnt
`endif
);

  localparam logic [CNT_W-1:0] RUN_MAX_C = CNT_W'(MAX_RUN);
  localparam logic [CNT_W-1:0] RUN_PRE_C = CNT_W'(MAX_RUN - 1);

  bs_state_t        state_r, state_nxt_s, eff_state_s;
  bs_mode_t         mode_r, eff_mode_s;
  logic [CNT_W-1:0] run_s, eff_run_s;
  logic             can_load_s, in_ready_s, accept_s;
  logic             run_at_max_s, run_hits_max_s;
  logic             load_s, load_bit_s, load_stuffed_s;
  logic             err_s, stuff_ev_s, run_inc_s, run_clr_s;
  logic             out_valid_r, out_bit_r, stuffed_r, stuff_err_r;

  // A start pulse restarts the packet context for this cycle's decisions,
  // so a bit accepted together with start belongs to the new packet.
  assign eff_state_s    = start ? PASS : state_r;
  assign eff_mode_s     = start ? bs_mode_t'(mode) : mode_r;
  assign eff_run_s      = start ? {CNT_W{1'b0}} : run_s;
  assign can_load_s     = ~out_valid_r | out_ready;
  assign in_ready_s     = ((state_r == ERR) & ~start) | (can_load_s & (state_r != INS));
  assign accept_s       = in_valid & in_ready_s;
  assign run_at_max_s   = (eff_run_s == RUN_MAX_C);
  assign run_hits_max_s = in_bit & (eff_run_s == RUN_PRE_C);

  counter #(.W(CNT_W)) u_run_cnt (
    .clk     (clk),
    .rst_L   (rst_L),
    .inc_cnt (run_inc_s),
    .clr_cnt (run_clr_s),
    .up      (1'b1),
    .count   (run_s)
  );

  // FSM state and latched packet mode
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_r <= PASS;
      mode_r  <= STUFF;
    end else begin
      state_r <= state_nxt_s;
      mode_r  <= eff_mode_s;
    end
  end

  // FSM next-state decision
  always_comb begin
    state_nxt_s = eff_state_s;
    case (eff_state_s)
      PASS: begin
        if (!accept_s) begin
          state_nxt_s = PASS;
        end else if (eff_mode_s == STUFF) begin
          if (run_hits_max_s) state_nxt_s = INS;
          else                state_nxt_s = PASS;
        end else begin
          if (run_at_max_s && in_bit) state_nxt_s = ERR;
          else                        state_nxt_s = PASS;
        end
      end
      INS: begin
        if (can_load_s) state_nxt_s = PASS;
        else            state_nxt_s = INS;
      end
      ERR:     state_nxt_s = ERR;
      default: state_nxt_s = PASS;
    endcase
  end

  // FSM outputs: output-register load, run counter control, event strobes
  always_comb begin
    load_s         = 1'b0;
    load_bit_s     = 1'b0;
    load_stuffed_s = 1'b0;
    err_s          = 1'b0;
    stuff_ev_s     = 1'b0;
    run_inc_s      = 1'b0;
    run_clr_s      = start;
    case (eff_state_s)
      PASS: begin
        if (!accept_s) begin
          load_s = 1'b0;
        end else if ((eff_mode_s == STUFF) || !run_at_max_s) begin
          load_s     = 1'b1;
          load_bit_s = in_bit;
          if (in_bit) run_inc_s = 1'b1;
          else        run_clr_s = 1'b1;
        end else begin
          // Slot where a stuffed 0 must appear: consume it, or flag a 1
          run_clr_s  = 1'b1;
          stuff_ev_s = ~in_bit;
          err_s      = in_bit;
        end
      end
      INS: begin
        if (can_load_s) begin
          load_s         = 1'b1;
          load_bit_s     = 1'b0;
          load_stuffed_s = 1'b1;
          run_clr_s      = 1'b1;
          stuff_ev_s     = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      ERR:     load_s = 1'b0;
      default: load_s = 1'b0;
    endcase
  end

  // Single output register; holds its contents while downstream stalls
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      out_valid_r <= 1'b0;
      out_bit_r   <= 1'b0;
      stuffed_r   <= 1'b0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      out_bit_r   <= load_bit_s;
      stuffed_r   <= load_stuffed_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
      stuffed_r   <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // One-cycle stuff error pulse
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) stuff_err_r <= 1'b0;
    else        stuff_err_r <= err_s;
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_bit   = out_bit_r;
  assign stuffed   = stuffed_r;
  assign stuff_err = stuff_err_r;

`ifdef BIT_STUFF_STATS_EN
  logic [15:0] stuff_cnt_r;
  logic [7:0]  err_cnt_r;

  // Saturating statistics, cleared only by reset (start leaves them alone)
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      stuff_cnt_r <= 16'd0;
      err_cnt_r   <= 8'd0;
    end else begin
      if (stuff_ev_s) stuff_cnt_r <= sat_inc16(stuff_cnt_r);
      if (err_s)      err_cnt_r   <= sat_inc8(err_cnt_r);
    end
  end

  assign stuff_cnt = stuff_cnt_r;
  assign err_cnt   = err_cnt_r;
`endif

endmodule

// File: tb/tb_bit_stuff_gen.sv
// Scoreboard bench for bit_stuff_gen: randomized packets against a
// behavioural model of the stuffing rules, plus directed corner cases.
module tb_bit_stuff_gen;

  localparam int MAX_RUN = 6;

  logic clk = 1'b0;
  logic rst_L = 1'b0;
  logic start = 1'b0, mode = 1'b0, in_valid = 1'b0, in_bit = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, out_bit, stuffed, stuff_err;

  logic rst3_L = 1'b0;
  logic start3 = 1'b0, mode3 = 1'b0, in_valid3 = 1'b0, in_bit3 = 1'b0, out_ready3 = 1'b1;
  logic in_ready3, out_valid3, out_bit3, stuffed3, stuff_err3;

`ifdef BIT_STUFF_STATS_EN
  logic [15:0] stuff_cnt, stuff_cnt3;
  logic [7:0]  err_cnt, err_cnt3;
`endif

  bit_stuff_gen #(.MAX_RUN(MAX_RUN)) dut (
    .clk(clk), .rst_L(rst_L), .start(start), .mode(mode),
    .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .out_valid(out_valid), .out_bit(out_bit), .out_ready(out_ready),
    .stuffed(stuffed), .stuff_err(stuff_err)
`ifdef BIT_STUFF_STATS_EN
    , .stuff_cnt(stuff_cnt), .err_cnt(err_cnt)
`endif
  );

  bit_stuff_gen #(.MAX_RUN(3)) dut3 (
    .clk(clk), .rst_L(rst3_L), .start(start3), .mode(mode3),
    .in_valid(in_valid3), .in_bit(in_bit3), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_bit(out_bit3), .out_ready(out_ready3),
    .stuffed(stuffed3), .stuff_err(stuff_err3)
`ifdef BIT_STUFF_STATS_EN
    , .stuff_cnt(stuff_cnt3), .err_cnt(err_cnt3)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [1:0] exp_q[$];   // {bit, stuffed}
  int m_run = 0;
  bit m_mode = 1'b0;
  bit m_err = 1'b0;
  int err_due = -5;
  int m_stuffs = 0;
  int m_errs = 0;
  int n_notready = 0;

  task automatic model_start(input bit m);
    m_run  = 0;
    m_mode = m;
    m_err  = 1'b0;
  endtask

  task automatic model_accept(input bit b);
    if (m_err) return;
    if (m_mode == 1'b0) begin
      exp_q.push_back({b, 1'b0});
      m_run = b ? m_run + 1 : 0;
      if (m_run == MAX_RUN) begin
        exp_q.push_back(2'b01);
        m_run = 0;
        m_stuffs++;
      end
    end else if (m_run == MAX_RUN) begin
      m_run = 0;
      if (b) begin
        m_err = 1'b1;
        m_errs++;
        err_due = cyc + 1;
      end else begin
        m_stuffs++;
      end
    end else begin
      exp_q.push_back({b, 1'b0});
      m_run = b ? m_run + 1 : 0;
    end
  endtask

  // ---------------- downstream ready generator ----------------
  bit rand_ready = 1'b0;
  bit stall_on_stuff = 1'b0;
  int stall_left = 0;

  always @(posedge clk) begin
    #1;
    if (stall_on_stuff && out_valid && stuffed) begin
      stall_left = 3;
      stall_on_stuff = 1'b0;
    end
    if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else if (rand_ready) begin
      out_ready = ($urandom_range(0, 9) < 7);
    end else begin
      out_ready = 1'b1;
    end
  end

  // ---------------- monitor ----------------
  bit held = 1'b0;
  logic [1:0] held_v = 2'b00;

  always @(negedge clk) begin
    if (rst_L) begin
      check("stuff_err", {31'd0, stuff_err}, {31'd0, (err_due == cyc)});
      if (held) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_data", {30'd0, out_bit, stuffed}, {30'd0, held_v});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_out", {30'd0, out_bit, stuffed}, 32'hDEAD);
        end else begin
          check("out_data", {30'd0, out_bit, stuffed}, {30'd0, exp_q.pop_front()});
        end
      end
      held   = out_valid && !out_ready;
      held_v = {out_bit, stuffed};
    end else begin
      held = 1'b0;
    end
  end

  // ---------------- stimulus tasks (entered at posedge+1) ----------------
  task automatic send_bit(input bit b, input bit st, input bit m);
    int guard;
    bit done;
    guard = 0;
    done = 1'b0;
    in_valid = 1'b1; in_bit = b; start = st; mode = m;
    while (!done) begin
      @(negedge clk);
      if (start) model_start(mode);
      if (in_ready) begin
        model_accept(b);
        done = 1'b1;
      end else begin
        n_notready++;
      end
      @(posedge clk); #1;
      start = 1'b0;
      guard++;
      if (!done && guard > 200) begin
        check("send_timeout", 32'd0, 32'd1);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_start(input bit m);
    in_valid = 1'b0; start = 1'b1; mode = m;
    @(negedge clk);
    model_start(m);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int g;
    g = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && g < 500) begin
      @(posedge clk);
      g++;
    end
    #1;
    check("drain_empty", exp_q.size(), 32'd0);
    idle(2);
  endtask

  // send a bit pattern as one packet, first bit carrying start
  task automatic send_pkt(input bit m, input logic [31:0] bits, input int len);
    for (int i = len - 1; i >= 0; i--) send_bit(bits[i], (i == len - 1), m);
  endtask

  // ---------------- MAX_RUN=3 instance helpers ----------------
  logic [1:0] got3[$];
  always @(negedge clk) if (rst3_L && out_valid3) got3.push_back({out_bit3, stuffed3});

  task automatic send3(input bit b);
    int guard;
    guard = 0;
    in_valid3 = 1'b1; in_bit3 = b;
    @(negedge clk);
    while (!in_ready3 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("t6_ready", {31'd0, in_ready3}, 32'd1);
    @(posedge clk); #1;
    in_valid3 = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_bit", {31'd0, out_bit}, 32'd0);
    check("rst_stuffed", {31'd0, stuffed}, 32'd0);
    check("rst_stuff_err", {31'd0, stuff_err}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst3_out_valid", {31'd0, out_valid3}, 32'd0);
    #10;
    rst_L = 1'b1;
    rst3_L = 1'b1;
    @(posedge clk); #1;

    // 1: stuff 7 ones -> 11111101, one not-ready cycle
    n_notready = 0;
    send_pkt(1'b0, 32'h7F, 7);
    drain();
    check("t1_inready_low", n_notready, 32'd1);

    // 2: unstuff 111111 0 1 -> 1111111
    send_pkt(1'b1, 32'hFD, 8);
    drain();

    // 3: unstuff 7 ones -> error, then dropped bits, restart, 0
    send_pkt(1'b1, 32'h7F, 7);
    send_bit(1'b1, 1'b0, 1'b1);
    send_bit(1'b0, 1'b0, 1'b1);
    idle(2);
    pulse_start(1'b1);
    send_bit(1'b0, 1'b0, 1'b1);
    drain();

    // 4: stall downstream while the stuffed 0 sits in the output register
    stall_on_stuff = 1'b1;
    send_pkt(1'b0, 32'h7F, 7);
    drain();
    check("t4_stall_taken", {31'd0, stall_on_stuff}, 32'd0);

    // 5: restart mid-run, then switch mode on the next start
    send_pkt(1'b0, 32'h1F, 5);
    send_pkt(1'b0, 32'h1F, 5);
    send_pkt(1'b1, 32'h7F, 7);
    drain();

    // randomized packets with random back-pressure and gaps
    rand_ready = 1'b1;
    for (int p = 0; p < 40; p++) begin
      bit pm;
      int len;
      pm = 1'($urandom_range(0, 1));
      len = $urandom_range(4, 40);
      for (int i = 0; i < len; i++) begin
        send_bit(($urandom_range(0, 9) < 8), (i == 0), pm);
        if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 2));
      end
      drain();
    end
    rand_ready = 1'b0;
    idle(4);

`ifdef BIT_STUFF_STATS_EN
    check("stuff_cnt", {16'd0, stuff_cnt}, m_stuffs);
    check("err_cnt", {24'd0, err_cnt}, m_errs);
`endif

    // 6: MAX_RUN=3, 1111 -> 11101
    got3.delete();
    for (int i = 0; i < 4; i++) send3(1'b1);
    idle(4);
    check("t6_len", got3.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      logic [1:0] e;
      e = (i == 3) ? 2'b01 : 2'b10;
      if (i < got3.size()) check("t6_data", {30'd0, got3[i]}, {30'd0, e});
    end
    // reset mid-packet: output drops at once, run restarts from zero
    send3(1'b1);
    send3(1'b1);
    check("t6_pre_rst_valid", {31'd0, out_valid3}, 32'd1);
    rst3_L = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, out_valid3}, 32'd0);
    check("t6_rst_stuffed", {31'd0, stuffed3}, 32'd0);
    @(negedge clk);
    rst3_L = 1'b1;
    @(posedge clk); #1;
    got3.delete();
    send3(1'b1);
    send3(1'b1);
    idle(4);
    check("t6_post_len", got3.size(), 32'd2);
    for (int i = 0; i < 2; i++) begin
      if (i < got3.size()) check("t6_post_data", {30'd0, got3[i]}, 32'd2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
